// File: rtl/segment_rx.sv
// segment_rx: receives a multiplexed 4-digit seven-segment display bus
// (active-low digit select plus active-high segment code), debounces each
// presented digit and assembles complete frames into a 16-bit hex value.
// A digit commits once its select/segment pair has been seen unchanged on
// STABLE_CNT consecutive rising edges. When all four digits have committed,
// value is loaded and frame_valid pulses for one cycle.
// Optional build macro: SEGMENT_RX_DP_EN adds the dp output and captures each
// digit's decimal point. Without it, any pattern with the decimal point lit
// is treated as unrecognised.
module segment_rx #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dsel_in,
    input  logic [7:0]  seg_in,
    input  logic        clear,
`ifdef SEGMENT_RX_DP_EN
    output logic [3:0]  dp,
`endif
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_ok,
    output logic        err
);

    // The run counter holds (edges seen unchanged - 1), so a digit is stable
    // for STABLE_CNT edges when the counter already reads STABLE_CNT-2 and the
    // input still matches the sample.
    localparam logic [3:0] RUN_HIT = 4'(STABLE_CNT - 2);
    localparam logic [3:0] RUN_MAX = 4'hF;

    logic [11:0] sample_q;
    logic [3:0]  run_q, run_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] value_q;
    logic        frame_valid_q;
    logic [3:0]  digit_ok_q, ok_set;
    logic        err_q;
    logic [3:0]  hdp_q, hdp_d;
    logic [3:0]  dp_q;

    logic        same, stable;
    logic        sel_ok;
    logic [1:0]  sel_idx;
    logic        known;
    logic [3:0]  nib;
    logic        commit, bad, frame_done;

    // Select decode: exactly one active-low line picks a digit; anything else
    // (blank or several lines low) is not a digit.
    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (dsel_in)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    // Segment decode of seg_in[6:0] into a hex nibble.
    always_comb begin
        known = 1'b1;
        nib   = 4'h0;
        case (seg_in[6:0])
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: known = 1'b0;
        endcase
`ifndef SEGMENT_RX_DP_EN
        // No decimal-point support: a lit DP makes the pattern unrecognised.
        if (seg_in[7]) known = 1'b0;
`endif
    end

    // Stability detection, commit qualification and next holding contents.
    always_comb begin
        same       = ({dsel_in, seg_in} == sample_q);
        stable     = same && (run_q == RUN_HIT);
        commit     = stable && sel_ok && known && !clear;
        bad        = stable && sel_ok && !known;
        if (clear || !same)       run_d = 4'd0;
        else if (run_q == RUN_MAX) run_d = RUN_MAX;
        else                      run_d = run_q + 4'd1;
        ok_set     = digit_ok_q | (commit ? (4'b0001 << sel_idx) : 4'b0000);
        frame_done = commit && (ok_set == 4'hF);
        hold_d     = hold_q;
        hdp_d      = hdp_q;
        if (commit) begin
            hold_d[{sel_idx, 2'b00} +: 4] = nib;
            hdp_d[sel_idx]                = seg_in[7];
        end
    end

    // Sample/run tracking, digit holding, frame assembly and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q      <= {4'hF, 8'h00};
            run_q         <= 4'd0;
            hold_q        <= 16'h0000;
            hdp_q         <= 4'h0;
            value_q       <= 16'h0000;
            dp_q          <= 4'h0;
            frame_valid_q <= 1'b0;
            digit_ok_q    <= 4'h0;
            err_q         <= 1'b0;
        end else begin
            sample_q <= {dsel_in, seg_in};
            run_q    <= run_d;
            hold_q   <= hold_d;
            hdp_q    <= hdp_d;
            if (clear) begin
                digit_ok_q    <= 4'h0;
                err_q         <= 1'b0;
                frame_valid_q <= 1'b0;
            end else begin
                digit_ok_q    <= frame_done ? 4'h0 : ok_set;
                err_q         <= err_q | bad;
                frame_valid_q <= frame_done;
                if (frame_done) begin
                    value_q <= hold_d;
                    dp_q    <= hdp_d;
                end
            end
        end
    end

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign digit_ok    = digit_ok_q;
    assign err         = err_q;
`ifdef SEGMENT_RX_DP_EN
    assign dp          = dp_q;
`else
    logic unused_dp;
    assign unused_dp = ^dp_q;
`endif

endmodule

// File: tb/tb_segment_rx.sv
// Testbench for segment_rx: directed scenarios followed by randomized digit
// traffic, every cycle compared against a frame-level reference model.
module tb_segment_rx;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  dsel_in;
    logic [7:0]  seg_in;
    logic        clear;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_ok;
    logic        err;
    logic [3:0]  dp;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int fv_seen   = 0;

    segment_rx #(.STABLE_CNT(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dsel_in     (dsel_in),
        .seg_in      (seg_in),
        .clear       (clear),
`ifdef SEGMENT_RX_DP_EN
        .dp          (dp),
`endif
        .value       (value),
        .frame_valid (frame_valid),
        .digit_ok    (digit_ok),
        .err         (err)
    );

`ifndef SEGMENT_RX_DP_EN
    assign dp = 4'h0;
`endif

    // Clock: 25 MHz
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Reference model state
    logic [6:0]  codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [11:0] m_prev;
    int          m_run;
    logic [3:0]  m_hold [4];
    logic [3:0]  m_hdp;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_ok;
    logic        m_err;
    logic        m_fv;

    function automatic int find_code(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic int find_digit(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (d == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = 12'hF00;
        m_run  = 1;
        for (int i = 0; i < 4; i++) m_hold[i] = 4'h0;
        m_hdp = 4'h0; m_val = 16'h0; m_dp = 4'h0;
        m_ok = 4'h0; m_err = 1'b0; m_fv = 1'b0;
    endtask

    // One rising edge of the model: count how many edges the current input
    // has been seen in a row and commit on exactly the STABLE_CNT-th one.
    task automatic model_edge(input logic [3:0] d, input logic [7:0] s, input logic c);
        int dig, code;
        bit valid;
        if ({d, s} == m_prev) m_run++; else m_run = 1;
        m_prev = {d, s};
        m_fv = 1'b0;
        if (c) begin
            m_ok = 4'h0; m_err = 1'b0; m_run = 1;
        end else if (m_run == S) begin
            dig = find_digit(d);
            if (dig >= 0) begin
                code = find_code(s[6:0]);
`ifdef SEGMENT_RX_DP_EN
                valid = (code >= 0);
`else
                valid = (code >= 0) && !s[7];
`endif
                if (valid) begin
                    m_hold[dig] = 4'(code);
                    m_hdp[dig]  = s[7];
                    m_ok[dig]   = 1'b1;
                    if (m_ok == 4'hF) begin
                        m_val = {m_hold[3], m_hold[2], m_hold[1], m_hold[0]};
                        m_dp  = m_hdp;
                        m_ok  = 4'h0;
                        m_fv  = 1'b1;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // Scoreboard comparison
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value"}, value, m_val);
        check({tag, ".frame_valid"}, 16'(frame_valid), 16'(m_fv));
        check({tag, ".digit_ok"}, 16'(digit_ok), 16'(m_ok));
        check({tag, ".err"}, 16'(err), 16'(m_err));
`ifdef SEGMENT_RX_DP_EN
        check({tag, ".dp"}, 16'(dp), 16'(m_dp));
`endif
    endtask

    // Driver: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic [3:0] d, input logic [7:0] s, input logic c, input string tag);
        dsel_in = d; seg_in = s; clear = c;
        @(posedge clk);
        model_edge(d, s, c);
        #1;
        if (frame_valid) fv_seen++;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n, input string tag);
        repeat (n) step(d, s, 1'b0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] dsel_pool [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0011, 4'b0000};
        logic [3:0] rd;
        logic [7:0] rs;
        int r;

        rst_n = 1'b0; dsel_in = 4'hF; seg_in = 8'h00; clear = 1'b0;
        model_reset();
        #5;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single digit commits on the 4th edge, once per stable interval
        hold(4'b1110, 8'h06, 3, "d0_pre");
        check("d0_not_yet", 16'(digit_ok), 16'h0000);
        hold(4'b1110, 8'h06, 1, "d0_commit");
        check("d0_commit_ok", 16'(digit_ok), 16'h0001);
        hold(4'b1110, 8'h06, 20, "d0_held");
        check("d0_held_ok", 16'(digit_ok), 16'h0001);
        step(4'hF, 8'h00, 1'b1, "clr0");

        // Full frame assembly
        fv_seen = 0;
        hold(4'b1110, 8'h3F, 5, "f_d0");
        hold(4'b1101, 8'h5B, 5, "f_d1");
        hold(4'b1011, 8'h66, 5, "f_d2");
        hold(4'b0111, 8'h71, 4, "f_d3");
        check("frame_fv", 16'(frame_valid), 16'h0001);
        hold(4'b0111, 8'h71, 1, "f_d3b");
        check("frame_value", value, 16'hF420);
        check("frame_ok_zero", 16'(digit_ok), 16'h0000);
        check("frame_one_pulse", 16'(fv_seen), 16'h0001);

        // Bouncing segment code never commits
        for (int i = 0; i < 4; i++) begin
            hold(4'b1101, 8'h06, 2, "bounce");
            hold(4'b1101, 8'h07, 2, "bounce");
        end
        check("bounce_ok", 16'(digit_ok), 16'h0000);

        // Unrecognised pattern sets err; clear drops it
        hold(4'b1011, 8'h00, 4, "bad_pat");
        check("bad_err", 16'(err), 16'h0001);
        check("bad_ok", 16'(digit_ok), 16'h0000);
        step(4'b1011, 8'h00, 1'b1, "bad_clr");
        check("bad_clr_err", 16'(err), 16'h0000);

        // Decimal point on d3
        hold(4'b0111, 8'hBF, 4, "dp_d3");
`ifdef SEGMENT_RX_DP_EN
        check("dp_d3_ok", 16'(digit_ok), 16'h0008);
        hold(4'b1110, 8'h3F, 5, "dp_d0");
        hold(4'b1101, 8'h06, 5, "dp_d1");
        hold(4'b1011, 8'h5B, 4, "dp_d2");
        check("dp_value", value, 16'h0210);
        check("dp_dp", 16'(dp), 16'h0008);
`else
        check("dp_d3_err", 16'(err), 16'h0001);
        check("dp_d3_ok", 16'(digit_ok), 16'h0000);
`endif
        step(4'hF, 8'h00, 1'b1, "clr1");

        // Reset mid-frame discards partial frame and value
        hold(4'b1110, 8'h06, 5, "r_d0");
        hold(4'b1101, 8'h06, 5, "r_d1");
        hold(4'b1011, 8'h06, 5, "r_d2");
        pulse_reset("mid_reset");
        fv_seen = 0;
        hold(4'b0111, 8'h06, 5, "r_d3");
        check("rst_ok", 16'(digit_ok), 16'h0008);
        check("rst_value", value, 16'h0000);
        check("rst_no_fv", 16'(fv_seen), 16'h0000);

        // Randomized traffic
        for (int seg_n = 0; seg_n < 400; seg_n++) begin
            r = $urandom_range(0, 99);
            rd = (r < 85) ? dsel_pool[$urandom_range(0, 3)] : dsel_pool[$urandom_range(4, 6)];
            r = $urandom_range(0, 99);
            if (r < 70)      rs = {1'b0, codes[$urandom_range(0, 15)]};
            else if (r < 85) rs = 8'($urandom_range(0, 255));
            else             rs = {1'b1, codes[$urandom_range(0, 15)]};
            r = $urandom_range(1, (seg_n % 10 == 0) ? 20 : 6);
            for (int k = 0; k < r; k++)
                step(rd, rs, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, "rand");
            if ($urandom_range(0, 59) == 0) pulse_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
